// File: rtl/uart_tx_scheduler_if.sv
// Purpose: bundles the two requester paths and the UART TX load/busy pins of the scheduler.
// Latency: none, wiring only.
// Backpressure: req is held by the source until its ack; tx_busy paces the scheduler.
interface uart_tx_scheduler_if;
  logic        rf_req;
  logic [7:0]  rf_data;
  logic        rf_ack;
  logic        alu_req;
  logic [15:0] alu_data;
  logic        alu_ack;
  logic        tx_busy;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        sched_busy;
  logic        err_timeout;

  // Scheduler side.
  modport master (
    input  rf_req, rf_data, alu_req, alu_data, tx_busy,
    output rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy, err_timeout
  );

  // Requesters plus UART TX side.
  modport slave (
    output rf_req, rf_data, alu_req, alu_data, tx_busy,
    input  rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Purpose: shares one UART TX between the reg-file byte path and the two-byte ALU result path.
// Latency: request seen in IDLE -> ack + load strobe on the next cycle; all outputs registered.
// Backpressure: requests wait while the scheduler is not IDLE; bytes are paced by tx_busy rise/fall.
module uart_tx_scheduler #(
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  uart_tx_scheduler_if.master bus
);

  localparam int            CW       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   hold_q, hold_d;
  logic [1:0]    nbytes_q, nbytes_d;
  logic          idx_q, idx_d;
  logic          rr_alu_q, rr_alu_d;   // 1: ALU wins the next tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rf_ack_q, rf_ack_d;
  logic          alu_ack_q, alu_ack_d;
  logic          valid_q, valid_d;
  logic [7:0]    pdata_q, pdata_d;
  logic          sched_busy_q, sched_busy_d;
  logic          err_q, err_d;

  logic          grant_rf;
  logic          grant_alu;
  logic [1:0]    idx_inc;
  logic          more_bytes;

  // Round-robin only matters on a tie; a lone requester always wins.
  assign grant_rf   = bus.rf_req  & (~bus.alu_req | ~rr_alu_q);
  assign grant_alu  = bus.alu_req & (~bus.rf_req  |  rr_alu_q);
  assign idx_inc    = {1'b0, idx_q} + 2'd1;
  assign more_bytes = idx_inc < nbytes_q;

  // State and registered outputs; reset drops any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      hold_q       <= 16'h0000;
      nbytes_q     <= 2'd0;
      idx_q        <= 1'b0;
      rr_alu_q     <= 1'b0;
      cnt_q        <= '0;
      rf_ack_q     <= 1'b0;
      alu_ack_q    <= 1'b0;
      valid_q      <= 1'b0;
      pdata_q      <= 8'h00;
      sched_busy_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      nbytes_q     <= nbytes_d;
      idx_q        <= idx_d;
      rr_alu_q     <= rr_alu_d;
      cnt_q        <= cnt_d;
      rf_ack_q     <= rf_ack_d;
      alu_ack_q    <= alu_ack_d;
      valid_q      <= valid_d;
      pdata_q      <= pdata_d;
      sched_busy_q <= sched_busy_d;
      err_q        <= err_d;
    end
  end

  // Next state and next output values; strobes and acks are computed one cycle early
  // so that they are registered and line up with the LOAD cycle.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    nbytes_d  = nbytes_q;
    idx_d     = idx_q;
    rr_alu_d  = rr_alu_q;
    cnt_d     = cnt_q;
    rf_ack_d  = 1'b0;
    alu_ack_d = 1'b0;
    valid_d   = 1'b0;
    pdata_d   = pdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (grant_rf) begin
          hold_d   = {8'h00, bus.rf_data};
          nbytes_d = 2'd1;
          idx_d    = 1'b0;
          rr_alu_d = 1'b1;
          rf_ack_d = 1'b1;
          valid_d  = 1'b1;
          pdata_d  = bus.rf_data;
          state_d  = LOAD;
        end else if (grant_alu) begin
          hold_d    = bus.alu_data;
          nbytes_d  = 2'd2;
          idx_d     = 1'b0;
          rr_alu_d  = 1'b0;
          alu_ack_d = 1'b1;
          valid_d   = 1'b1;
          pdata_d   = bus.alu_data[7:0];
          state_d   = LOAD;
        end
      end

      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end

      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CNT_LAST) begin
          // TX never accepted the byte: flag it and abandon the rest of the frame.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (more_bytes) begin
            idx_d   = idx_inc[0];
            valid_d = 1'b1;
            pdata_d = idx_inc[0] ? hold_q[15:8] : hold_q[7:0];
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    sched_busy_d = (state_d != IDLE);
  end

  assign bus.rf_ack        = rf_ack_q;
  assign bus.alu_ack       = alu_ack_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.tx_p_data     = pdata_q;
  assign bus.sched_busy    = sched_busy_q;
  assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: directed bench for uart_tx_scheduler with a UART TX busy model and held-request drivers.
// Latency: TX model raises busy the cycle after a strobe and holds it for 10 cycles.
// Backpressure: requesters hold req until ack; a hold flag can keep a request up across an ack.
module tb_uart_tx_scheduler;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(.BUSY_TIMEOUT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  int rf_pending = 0;
  int alu_pending = 0;
  bit alu_hold = 1'b0;
  bit tx_normal = 1'b1;
  int busy_left = 0;

  logic [7:0] s_dat[$];
  int         s_cyc[$];
  logic [1:0] s_ack[$];
  int rf_acks = 0;
  int alu_acks = 0;
  int sb_fall = -1;
  int err_rise = -1;
  logic prev_sb = 1'b0;
  logic prev_err = 1'b0;

  always @(posedge CLK) cyc = cyc + 1;

  // Requester drivers, UART TX busy model and output monitor, all away from the active edge.
  always @(negedge CLK) begin
    if (bus.rf_ack && rf_pending > 0) rf_pending--;
    if (bus.alu_ack && !alu_hold && alu_pending > 0) alu_pending--;
    bus.rf_req  = (rf_pending > 0);
    bus.alu_req = (alu_pending > 0);

    if (RST) begin
      busy_left   = 0;
      bus.tx_busy = 1'b0;
      prev_sb     = 1'b0;
      prev_err    = 1'b0;
    end else begin
      if (busy_left > 0) begin
        bus.tx_busy = 1'b1;
        busy_left--;
      end else begin
        bus.tx_busy = 1'b0;
      end
      if (bus.tx_data_valid && tx_normal) busy_left = 10;

      if (bus.tx_data_valid) begin
        s_dat.push_back(bus.tx_p_data);
        s_cyc.push_back(cyc);
        s_ack.push_back({bus.rf_ack, bus.alu_ack});
      end
      if (bus.rf_ack) rf_acks++;
      if (bus.alu_ack) alu_acks++;
      if (prev_sb && !bus.sched_busy) sb_fall = cyc;
      if (!prev_err && bus.err_timeout) err_rise = cyc;
      prev_sb  = bus.sched_busy;
      prev_err = bus.err_timeout;
    end
  end

  task automatic clear_log();
    s_dat.delete();
    s_cyc.delete();
    s_ack.delete();
    rf_acks  = 0;
    alu_acks = 0;
    sb_fall  = -1;
    err_rise = -1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(rf_pending == 0 && alu_pending == 0 && !bus.sched_busy) && n < 400);
    repeat (3) @(negedge CLK);
    n_total++;
    if (n >= 400) $display("FAIL wait_done: scheduler still busy after %0d cycles, required idle", n);
    else n_pass++;
  endtask

  task automatic wait_strobe();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.tx_data_valid && n < 200);
    n_total++;
    if (n >= 200) $display("FAIL wait_strobe: no tx_data_valid in %0d cycles", n);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_total++; if (bus.rf_ack !== 1'b0) $display("FAIL reset_rf_ack got %b exp 0", bus.rf_ack); else n_pass++;
    n_total++; if (bus.alu_ack !== 1'b0) $display("FAIL reset_alu_ack got %b exp 0", bus.alu_ack); else n_pass++;
    n_total++; if (bus.tx_data_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.tx_data_valid); else n_pass++;
    n_total++; if (bus.tx_p_data !== 8'h00) $display("FAIL reset_p_data got %h exp 00", bus.tx_p_data); else n_pass++;
    n_total++; if (bus.sched_busy !== 1'b0) $display("FAIL reset_sched_busy got %b exp 0", bus.sched_busy); else n_pass++;
    n_total++; if (bus.err_timeout !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err_timeout); else n_pass++;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_total++; if (bus.sched_busy !== 1'b0) $display("FAIL idle_no_req_busy got %b exp 0", bus.sched_busy); else n_pass++;
  endtask

  task automatic test_rf_single();
    clear_log();
    bus.rf_data = 8'hA5;
    rf_pending  = 1;
    wait_done();
    n_total++; if (s_dat.size() !== 1) $display("FAIL rf_strobe_count got %0d exp 1", s_dat.size()); else n_pass++;
    if (s_dat.size() >= 1) begin
      n_total++; if (s_dat[0] !== 8'hA5) $display("FAIL rf_byte got %h exp a5", s_dat[0]); else n_pass++;
      n_total++; if (s_ack[0] !== 2'b10) $display("FAIL rf_ack_with_strobe got %b exp 10", s_ack[0]); else n_pass++;
      n_total++; if (sb_fall - s_cyc[0] !== 12) $display("FAIL rf_sched_busy_fall got %0d exp 12", sb_fall - s_cyc[0]); else n_pass++;
    end
    n_total++; if (rf_acks !== 1) $display("FAIL rf_ack_count got %0d exp 1", rf_acks); else n_pass++;
  endtask

  task automatic test_alu();
    clear_log();
    bus.alu_data = 16'h1234;
    alu_pending  = 1;
    wait_done();
    n_total++; if (s_dat.size() !== 2) $display("FAIL alu_strobe_count got %0d exp 2", s_dat.size()); else n_pass++;
    if (s_dat.size() >= 2) begin
      n_total++; if (s_dat[0] !== 8'h34) $display("FAIL alu_lo got %h exp 34", s_dat[0]); else n_pass++;
      n_total++; if (s_dat[1] !== 8'h12) $display("FAIL alu_hi got %h exp 12", s_dat[1]); else n_pass++;
      n_total++; if (s_ack[0] !== 2'b01) $display("FAIL alu_ack_first got %b exp 01", s_ack[0]); else n_pass++;
      n_total++; if (s_ack[1] !== 2'b00) $display("FAIL alu_ack_second got %b exp 00", s_ack[1]); else n_pass++;
      n_total++; if (s_cyc[1] - s_cyc[0] !== 12) $display("FAIL alu_byte_gap got %0d exp 12", s_cyc[1] - s_cyc[0]); else n_pass++;
    end
    n_total++; if (alu_acks !== 1) $display("FAIL alu_ack_count got %0d exp 1", alu_acks); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_dat [6];
    logic [1:0] exp_ack [6];
    int         exp_off [6];
    exp_dat = '{8'hA5, 8'h34, 8'h12, 8'hA5, 8'h34, 8'h12};
    exp_ack = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
    exp_off = '{0, 13, 25, 38, 51, 63};
    do_reset();
    clear_log();
    bus.rf_data  = 8'hA5;
    bus.alu_data = 16'h1234;
    rf_pending   = 2;
    alu_pending  = 2;
    wait_done();
    n_total++; if (s_dat.size() !== 6) $display("FAIL rr_strobe_count got %0d exp 6", s_dat.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i < s_dat.size()) begin
        n_total++; if (s_dat[i] !== exp_dat[i]) $display("FAIL rr_byte[%0d] got %h exp %h", i, s_dat[i], exp_dat[i]); else n_pass++;
        n_total++; if (s_ack[i] !== exp_ack[i]) $display("FAIL rr_ack[%0d] got %b exp %b", i, s_ack[i], exp_ack[i]); else n_pass++;
        n_total++; if (s_cyc[i] - s_cyc[0] !== exp_off[i]) $display("FAIL rr_time[%0d] got %0d exp %0d", i, s_cyc[i] - s_cyc[0], exp_off[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    clear_log();
    tx_normal    = 1'b0;
    bus.alu_data = 16'h1234;
    alu_pending  = 1;
    wait_done();
    n_total++; if (s_dat.size() !== 1) $display("FAIL to_strobe_count got %0d exp 1", s_dat.size()); else n_pass++;
    if (s_dat.size() >= 1) begin
      n_total++; if (s_dat[0] !== 8'h34) $display("FAIL to_byte got %h exp 34", s_dat[0]); else n_pass++;
      n_total++; if (err_rise - s_cyc[0] !== 5) $display("FAIL to_err_time got %0d exp 5", err_rise - s_cyc[0]); else n_pass++;
      n_total++; if (sb_fall - s_cyc[0] !== 5) $display("FAIL to_idle_time got %0d exp 5", sb_fall - s_cyc[0]); else n_pass++;
    end
    n_total++; if (bus.err_timeout !== 1'b1) $display("FAIL to_err got %b exp 1", bus.err_timeout); else n_pass++;
    clear_log();
    tx_normal   = 1'b1;
    bus.rf_data = 8'hA5;
    rf_pending  = 1;
    wait_done();
    n_total++; if (s_dat.size() !== 1) $display("FAIL to_next_count got %0d exp 1", s_dat.size()); else n_pass++;
    n_total++; if (bus.err_timeout !== 1'b1) $display("FAIL to_err_sticky got %b exp 1", bus.err_timeout); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    bus.alu_data = 16'h1234;
    alu_hold     = 1'b1;
    alu_pending  = 1;
    wait_strobe();
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_total++; if (bus.tx_p_data !== 8'h00) $display("FAIL rm_p_data got %h exp 00", bus.tx_p_data); else n_pass++;
    n_total++; if (bus.sched_busy !== 1'b0) $display("FAIL rm_sched_busy got %b exp 0", bus.sched_busy); else n_pass++;
    n_total++; if (bus.err_timeout !== 1'b0) $display("FAIL rm_err got %b exp 0", bus.err_timeout); else n_pass++;
    n_total++; if ({bus.tx_data_valid, bus.alu_ack} !== 2'b00) $display("FAIL rm_valid_ack got %b exp 00", {bus.tx_data_valid, bus.alu_ack}); else n_pass++;
    RST      = 1'b0;
    alu_hold = 1'b0;
    wait_done();
    n_total++; if (s_dat.size() !== 3) $display("FAIL rm_strobe_count got %0d exp 3", s_dat.size()); else n_pass++;
    if (s_dat.size() >= 3) begin
      n_total++; if (s_dat[1] !== 8'h34) $display("FAIL rm_reserve_lo got %h exp 34", s_dat[1]); else n_pass++;
      n_total++; if (s_dat[2] !== 8'h12) $display("FAIL rm_reserve_hi got %h exp 12", s_dat[2]); else n_pass++;
      n_total++; if (s_cyc[1] - s_cyc[0] !== 6) $display("FAIL rm_reserve_time got %0d exp 6", s_cyc[1] - s_cyc[0]); else n_pass++;
    end
  endtask

  task automatic test_pending_wait_lo();
    int snap;
    do_reset();
    clear_log();
    bus.rf_data = 8'hA5;
    rf_pending  = 1;
    wait_strobe();
    repeat (4) @(negedge CLK);
    bus.rf_data  = 8'h5A;
    bus.alu_data = 16'h1234;
    rf_pending   = 1;
    alu_pending  = 1;
    snap = rf_acks + alu_acks;
    repeat (8) @(negedge CLK);
    n_total++; if (rf_acks + alu_acks !== snap) $display("FAIL pw_no_early_ack got %0d exp %0d", rf_acks + alu_acks, snap); else n_pass++;
    n_total++; if (bus.sched_busy !== 1'b0) $display("FAIL pw_idle_gap got %b exp 0", bus.sched_busy); else n_pass++;
    wait_done();
    n_total++; if (s_dat.size() !== 4) $display("FAIL pw_strobe_count got %0d exp 4", s_dat.size()); else n_pass++;
    if (s_dat.size() >= 4) begin
      n_total++; if ({s_dat[1], s_dat[2], s_dat[3]} !== 24'h34125A) $display("FAIL pw_order got %h exp 34125a", {s_dat[1], s_dat[2], s_dat[3]}); else n_pass++;
      n_total++; if ({s_ack[1], s_ack[3]} !== 4'b0110) $display("FAIL pw_acks got %b exp 0110", {s_ack[1], s_ack[3]}); else n_pass++;
      n_total++; if (s_cyc[1] - s_cyc[0] !== 13) $display("FAIL pw_gap got %0d exp 13", s_cyc[1] - s_cyc[0]); else n_pass++;
    end
  endtask

  initial begin
    bus.rf_req   = 1'b0;
    bus.alu_req  = 1'b0;
    bus.rf_data  = 8'h00;
    bus.alu_data = 16'h0000;
    bus.tx_busy  = 1'b0;
    test_reset();
    test_rf_single();
    test_alu();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_pending_wait_lo();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
